// File: rtl/spike_rate_avg.sv
// Purpose: moving average of the last 2^LOG2_DEPTH spike counts. The upstream window strobe is
//          synchronised into clk, and each window event pushes cnt_in into a circular buffer that
//          keeps a running sum.
// Latency: rate_valid pulses after the 4th rising clk edge that samples win_tick high. That is
//          2 synchroniser edges, 1 edge for the sum update and 1 edge for the rate load.
// Backpressure: none. A window event is always accepted unless clear is high on the same edge,
//          in which case the event is dropped.
// Ports: clk, reset (async active-low), cnt_in[31:0], win_tick (async), clear (sync flush);
//        sum_out[32+LOG2_DEPTH-1:0], rate_out[31:0], rate_valid, primed.
module spike_rate_avg #(
    parameter int LOG2_DEPTH = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             cnt_in,
    input  logic                    win_tick,
    input  logic                    clear,
    output logic [32+LOG2_DEPTH-1:0] sum_out,
    output logic [31:0]             rate_out,
    output logic                    rate_valid,
    output logic                    primed
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = 32 + LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL = (LOG2_DEPTH + 1)'(DEPTH);

    logic [31:0]           buf_mem [DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr;
    logic [LOG2_DEPTH:0]   fill;
    logic [SW-1:0]         sum;
    logic                  s1, s2, s3;
    logic                  tick_p;
    logic                  upd;     // sum changed on the previous edge; rate loads on this one

    // The chain resets to 1, so a strobe that is already high at reset release looks like
    // "no edge". Only a fresh rising edge of win_tick produces an event.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= win_tick;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign tick_p = s2 & ~s3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            sum        <= '0;
            upd        <= 1'b0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) buf_mem[i] <= '0;
            wr_ptr     <= '0;
            fill       <= '0;
            sum        <= '0;
            upd        <= 1'b0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
        end else begin
            upd        <= tick_p;
            rate_valid <= upd;
            if (upd) rate_out <= sum[SW-1:LOG2_DEPTH];
            if (tick_p) begin
                // Add the new count and subtract the one it overwrites. Empty slots hold 0,
                // so the sum is correct before the buffer has filled.
                sum             <= sum + {{LOG2_DEPTH{1'b0}}, cnt_in}
                                       - {{LOG2_DEPTH{1'b0}}, buf_mem[wr_ptr]};
                buf_mem[wr_ptr] <= cnt_in;
                wr_ptr          <= wr_ptr + 1'b1;
                if (fill != FULL) fill <= fill + 1'b1;
            end
        end
    end

    assign sum_out = sum;
    assign primed  = (fill == FULL);

endmodule

// File: tb/tb_spike_rate_avg.sv
module tb_spike_rate_avg;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cnt_in;
    logic        win_tick;
    logic        clear;
    logic [34:0] sum_out;
    logic [31:0] rate_out;
    logic        rate_valid;
    logic        primed;

    int checks = 0;
    int errors = 0;
    int vcnt   = 0;                 // running count of rate_valid cycles

    // Reference model: the last 8 accepted counts, oldest first.
    logic [31:0] mq [$];

    spike_rate_avg #(.LOG2_DEPTH(3)) dut (
        .clk(clk), .reset(reset), .cnt_in(cnt_in), .win_tick(win_tick), .clear(clear),
        .sum_out(sum_out), .rate_out(rate_out), .rate_valid(rate_valid), .primed(primed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rate_valid) vcnt++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model_sum();
        logic [63:0] s = 0;
        foreach (mq[i]) s += 64'(mq[i]);
        return s;
    endfunction

    task automatic model_push(input logic [31:0] c);
        mq.push_back(c);
        if (mq.size() > 8) void'(mq.pop_front());
    endtask

    // One full window: rising edge, 4 cycles high, then 4 cycles low so everything settles.
    task automatic tick(input logic [31:0] c);
        @(negedge clk);
        cnt_in   = c;
        win_tick = 1'b1;
        repeat (4) @(negedge clk);
        win_tick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic tick_chk(input string name, input logic [31:0] c);
        int v0;
        v0 = vcnt;
        tick(c);
        model_push(c);
        check({name, " sum"},    64'(sum_out),  model_sum());
        check({name, " rate"},   64'(rate_out), model_sum() >> 3);
        check({name, " primed"}, 64'(primed),   64'(mq.size() == 8));
        check({name, " pulses"}, 64'(vcnt - v0), 64'd1);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        mq.delete();
    endtask

    typedef struct {
        logic [31:0] cnt;
        logic [34:0] exp_sum;
        logic [31:0] exp_rate;
        logic        exp_primed;
    } vec_t;

    initial begin
        vec_t vt [9];
        int   v0;

        // Fill and slide: eight windows of 16, then one window of 0.
        for (int i = 0; i < 8; i++)
            vt[i] = '{32'd16, 35'(16 * (i + 1)), 32'(2 * (i + 1)), (i == 7)};
        vt[8] = '{32'd0, 35'd112, 32'd14, 1'b1};

        // Reset held low with random inputs; win_tick is high at release.
        reset = 1'b0; clear = 1'b0; win_tick = 1'b0; cnt_in = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt_in   = $urandom;
            win_tick = 1'($urandom);
            clear    = 1'($urandom);
        end
        win_tick = 1'b1;
        clear    = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        v0 = vcnt;
        check("reset sum",    64'(sum_out),  0);
        check("reset rate",   64'(rate_out), 0);
        check("reset valid",  64'(rate_valid), 0);
        check("reset primed", 64'(primed),   0);
        repeat (20) @(negedge clk);
        check("reset no pulse", 64'(vcnt - v0), 0);
        win_tick = 1'b0;
        repeat (3) @(negedge clk);

        // Single window with cycle-exact latency.
        @(negedge clk);
        cnt_in   = 32'd80;
        win_tick = 1'b1;
        @(negedge clk); check("lat e1 valid", 64'(rate_valid), 0);
        @(negedge clk); check("lat e2 valid", 64'(rate_valid), 0);
        @(negedge clk); check("lat e3 valid", 64'(rate_valid), 0);
        check("lat e3 sum", 64'(sum_out), 80);
        @(negedge clk); check("lat e4 valid", 64'(rate_valid), 1);
        check("lat e4 rate", 64'(rate_out), 10);
        @(negedge clk); check("lat e5 valid", 64'(rate_valid), 0);
        check("single primed", 64'(primed), 0);
        win_tick = 1'b0;
        repeat (4) @(negedge clk);
        do_clear();

        // Table-driven fill and slide.
        for (int i = 0; i < 9; i++) begin
            v0 = vcnt;
            tick(vt[i].cnt);
            check($sformatf("tbl%0d sum", i),    64'(sum_out),   64'(vt[i].exp_sum));
            check($sformatf("tbl%0d rate", i),   64'(rate_out),  64'(vt[i].exp_rate));
            check($sformatf("tbl%0d primed", i), 64'(primed),    64'(vt[i].exp_primed));
            check($sformatf("tbl%0d pulse", i),  64'(vcnt - v0), 1);
        end

        // Wrap: counts 0..7, then 100 overwrites slot 0.
        do_clear();
        for (int i = 0; i < 8; i++) tick_chk("wrap", 32'(i));
        tick_chk("wrap100", 32'd100);
        check("wrap sum exact", 64'(sum_out), 128);
        check("wrap wr_ptr", 64'(dut.wr_ptr), 1);

        // Extremes: every slot holds the maximum count.
        do_clear();
        for (int i = 0; i < 8; i++) tick_chk("max", 32'hFFFF_FFFF);
        check("max sum exact",  64'(sum_out),  64'h7_FFFF_FFF8);
        check("max rate exact", 64'(rate_out), 64'hFFFF_FFFF);

        // Clear coincident with the tick_p cycle drops the event.
        @(negedge clk);
        cnt_in   = 32'd55;
        win_tick = 1'b1;
        v0 = vcnt;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;               // tick_p is high going into the next edge
        @(negedge clk);
        clear = 1'b0;
        mq.delete();
        repeat (5) @(negedge clk);
        win_tick = 1'b0;
        repeat (4) @(negedge clk);
        check("clr sum",    64'(sum_out),   0);
        check("clr rate",   64'(rate_out),  0);
        check("clr primed", 64'(primed),    0);
        check("clr wr_ptr", 64'(dut.wr_ptr), 0);
        check("clr fill",   64'(dut.fill),  0);
        check("clr no pulse", 64'(vcnt - v0), 0);
        tick_chk("after clr", 32'd8);
        check("after clr rate exact", 64'(rate_out), 1);

        // Reset between the sum update and rate_valid discards the pending update.
        @(negedge clk);
        cnt_in   = 32'd400;
        win_tick = 1'b1;
        v0 = vcnt;
        repeat (3) @(negedge clk);  // sum updated; rate_valid due on the next edge
        reset = 1'b0;
        mq.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        win_tick = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst sum",   64'(sum_out),  0);
        check("midrst rate",  64'(rate_out), 0);
        check("midrst pulse", 64'(vcnt - v0), 0);

        // Randomised windows against the reference model, with occasional clears.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) do_clear();
            tick_chk($sformatf("rnd%0d", i),
                     ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
